fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch front end that writes the IF/ID pipeline register. Holds the PC and predicts the next PC with a 2-bit branch history table. Applies stall, redirect and halt requests from later stages. Drives the IF/ID control inputs: `pc`, `bpr`, `flush` and active-low `latchn`.

## Interface
- `PC_W`, 12: PC / instruction-memory byte-address width.
- `BHT_IDX_W`, 4: log2 of the number of BHT entries (16).
- `RESET_PC`, 0: PC value loaded on reset.

- `CLK`  in  1  sole clock; all state updates on rising edge.
- `RSTn`  in  1  synchronous active-low reset, sampled at the rising edge of `CLK`.
- `imem_addr_o`  out  PC_W  fetch address, always equal to the internal PC.
- `imem_data_i`  in  32  instruction at `imem_addr_o`, combinational read in the same cycle.
- `stall_i`  in  1  load-use stall: hold the PC and hold IF/ID.
- `redirect_i`  in  1  EX resolved a misprediction: refetch from `redirect_pc_i`.
- `redirect_pc_i`  in  PC_W  correct target.
- `bupd_i`  in  1  EX resolved a conditional branch: train the BHT.
- `bupd_pc_i`  in  PC_W  PC of the resolved branch.
- `bupd_taken_i`  in  1  actual branch outcome.
- `halt_i`  in  1  halt committed in WB.
- `pc_o`  out  PC_W  PC of the fetched instruction, toward IF/ID `pc_i`.
- `bpr_o`  out  1  predicted taken, toward IF/ID `bpr_i`.
- `flush_o`  out  1  the instruction being latched is invalid, toward IF/ID `flush_i`.
- `latchn_o`  out  1  active-low latch enable, toward IF/ID `latchn`.

## Operation
- States:
  - RUN: normal fetch.
  - HALTED: stopped; exited only by reset.
- Reset (`RSTn`=0 at an edge):
  - PC ← `RESET_PC`, state ← RUN.
  - All BHT entries ← 2'b01 (weakly not-taken).
- Decode for prediction, from `imem_data_i` in the same cycle:
  - isB: opcode 7'b1100011.
  - isJAL: opcode 7'b1101111.
  - B-immediate and J-immediate are sign-extended, then truncated to `PC_W`.
- BHT index = `PC[BHT_IDX_W+1:2]`.
- `bpr_o` = isJAL | (isB & bht[idx][1]).
- Predicted next PC:
  - `bpr_o`=1: PC + imm.
  - `bpr_o`=0: PC + 4.
  - All PC arithmetic is modulo 2^PC_W; wrap-around is silent.
- Per-cycle priority, highest first: reset > HALTED > `halt_i` > `redirect_i` > `stall_i` > normal.
  - HALTED: PC frozen, `flush_o`=1, `latchn_o`=0 (IF/ID fills with bubbles); all inputs ignored.
  - `halt_i`: state ← HALTED, PC frozen, `flush_o`=1, `latchn_o`=0. `halt_i` wins over a simultaneous redirect because the halt is older.
  - `redirect_i`: PC ← `redirect_pc_i`, `flush_o`=1, `latchn_o`=0. The wrong-path instruction is latched as a bubble. Redirect wins over a simultaneous stall.
  - `stall_i`: PC holds, `latchn_o`=1, `flush_o`=0.
  - normal: PC ← predicted next PC, `latchn_o`=0, `flush_o`=0.
- BHT training is independent of the priority chain. It is applied whenever `bupd_i`=1 in any state except HALTED, including during stall and redirect cycles.
  - Counter update: saturating increment if taken, saturating decrement if not taken, range 0..3.
  - Index = `bupd_pc_i[BHT_IDX_W+1:2]`.
- A same-cycle BHT read and write to the same index returns the old counter value; the new value is visible from the next cycle.

## Timing
- Values during and immediately after reset:
  - `imem_addr_o` = `pc_o` = `RESET_PC`.
  - `flush_o`=0, `latchn_o`=0.
  - `bpr_o` reflects decode of `imem_data_i`.
- `pc_o`, `imem_addr_o`: registered.
- `bpr_o`, `flush_o`, `latchn_o`: combinational from the current PC, state, `imem_data_i` and request inputs, valid in the same cycle.
- Redirect latency: `redirect_i` in cycle N → `pc_o` = `redirect_pc_i` in cycle N+1.
- Prediction latency: a taken prediction in cycle N → target on `pc_o` in cycle N+1. There is zero bubble on correct prediction.
- `halt_i` in cycle N → `flush_o` is 1 from cycle N onward, permanently until reset.
- Reset asserted mid-stall or mid-redirect overrides both: the state after the edge is exactly the reset state.

## Structure
- Shared package holds:
  - opcode constants `OPC_BRANCH` and `OPC_JAL`;
  - state encoding (RUN, HALTED);
  - counter constants `BHT_WNT`=2'b01 and `BHT_ST`=2'b11.
- One sub-module: `bht`, a 2^BHT_IDX_W × 2-bit table.
  - Combinational read port, synchronous saturating-update port, synchronous reset to 2'b01.
  - Exports the read-old-value-on-collision rule.
- Top level contains the PC register, immediate decode, next-PC adder/mux and state FSM.

## Test plan
- Sequential fetch: reset, then NOPs at `RESET_PC`=0 → `pc_o` = 0, 4, 8, …; `latchn_o`=0, `flush_o`=0, `bpr_o`=0. At PC 0xFFC, next `pc_o` = 0x000 (wrap).
- JAL at 0x010 with imm +0x20 → `bpr_o`=1 at 0x010; next `pc_o`=0x030.
- Training: B-type at 0x040, imm −8. With a fresh BHT → `bpr_o`=0. After two `bupd_i` taken updates at 0x040 → `bpr_o`=1, next `pc_o`=0x038. After three not-taken updates → `bpr_o`=0.
- Stall for 3 cycles at PC 0x020 → `pc_o` holds 0x020 and `latchn_o`=1 for 3 cycles, then the PC advances to 0x024.
- Redirect to 0x100 simultaneous with `stall_i` → `flush_o`=1 and `latchn_o`=0 that cycle; `pc_o`=0x100 in the next cycle.
- `halt_i` simultaneous with redirect to 0x200 → PC frozen, `flush_o`=1 forever. Later `redirect_i`/`bupd_i` are ignored. `RSTn`=0 → `pc_o`=0, state RUN.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared constants, state encoding and immediate decode for the fetch front end.
package fetch_ctrl_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [1:0] BHT_SNT = 2'b00;
  localparam logic [1:0] BHT_WNT = 2'b01;
  localparam logic [1:0] BHT_ST  = 2'b11;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_ctrl_bht.sv
// Branch history table: 2-bit saturating counters, combinational read,
// synchronous update. A same-cycle read of an updated entry sees the old value.
module bht
  import fetch_ctrl_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  localparam int N_ENT = 1 << IDX_W;

  logic [1:0] ctr_q [N_ENT];

  assign rd_ctr = ctr_q[rd_idx];

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      for (int i = 0; i < N_ENT; i++) ctr_q[i] <= BHT_WNT;
    end else if (upd_en) begin
      if (upd_taken) begin
        if (ctr_q[upd_idx] != BHT_ST) ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'd1;
      end else begin
        if (ctr_q[upd_idx] != BHT_SNT) ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'd1;
      end
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch front end: PC register, BHT-based next-PC prediction and
// stall/redirect/halt handling toward the IF/ID register.
//
//   state  | meaning
//   RUN    | normal fetch, honours halt > redirect > stall > predict
//   HALTED | PC frozen, IF/ID filled with bubbles until reset
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int              PC_W      = 12,
  parameter int              BHT_IDX_W = 4,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic            CLK,
  input  logic            RSTn,
  output logic [PC_W-1:0] imem_addr_o,
  input  logic [31:0]     imem_data_i,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [PC_W-1:0] redirect_pc_i,
  input  logic            bupd_i,
  input  logic [PC_W-1:0] bupd_pc_i,
  input  logic            bupd_taken_i,
  input  logic            halt_i,
  output logic [PC_W-1:0] pc_o,
  output logic            bpr_o,
  output logic            flush_o,
  output logic            latchn_o
);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pred_pc;
  logic [PC_W-1:0] pred_off;
  logic [1:0]      bht_ctr;
  logic            is_b, is_jal;
  logic            unused_bupd_bits;

  assign unused_bupd_bits = ^bupd_pc_i;

  bht #(.IDX_W(BHT_IDX_W)) u_bht (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .rd_idx    (pc_q[BHT_IDX_W+1:2]),
    .rd_ctr    (bht_ctr),
    .upd_en    (bupd_i && (state_q != HALTED)),
    .upd_idx   (bupd_pc_i[BHT_IDX_W+1:2]),
    .upd_taken (bupd_taken_i)
  );

  assign is_b   = (imem_data_i[6:0] == OPC_BRANCH);
  assign is_jal = (imem_data_i[6:0] == OPC_JAL);
  assign bpr_o  = is_jal | (is_b & bht_ctr[1]);

  always_comb begin
    pred_off = PC_W'(3'd4);
    if (bpr_o) pred_off = is_jal ? PC_W'(imm_j(imem_data_i)) : PC_W'(imm_b(imem_data_i));
  end

  assign pred_pc = pc_q + pred_off;

  // Reset outranks everything, so the reset cycle always shows a plain fetch.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    flush_o  = 1'b0;
    latchn_o = 1'b0;
    if (RSTn) begin
      case (state_q)
        HALTED: flush_o = 1'b1;
        default: begin
          if (halt_i) begin
            state_d = HALTED;
            flush_o = 1'b1;
          end else if (redirect_i) begin
            pc_d    = redirect_pc_i;
            flush_o = 1'b1;
          end else if (stall_i) begin
            latchn_o = 1'b1;
          end else begin
            pc_d = pred_pc;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign pc_o        = pc_q;
  assign imem_addr_o = pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl with hand-computed expectations.
module tb_fetch_ctrl;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] JAL32 = 32'h0200_00EF;  // jal ra, +0x20
  localparam logic [31:0] BM8   = 32'hFE00_0CE3;  // beq x0, x0, -8

  logic        CLK;
  logic        RSTn;
  logic [11:0] imem_addr_o;
  logic [31:0] imem_data_i;
  logic        stall_i, redirect_i, bupd_i, bupd_taken_i, halt_i;
  logic [11:0] redirect_pc_i, bupd_pc_i;
  logic [11:0] pc_o;
  logic        bpr_o, flush_o, latchn_o;

  int checks = 0;
  int errors = 0;

  fetch_ctrl #(.PC_W(12), .BHT_IDX_W(4), .RESET_PC(12'h000)) dut (
    .CLK           (CLK),
    .RSTn          (RSTn),
    .imem_addr_o   (imem_addr_o),
    .imem_data_i   (imem_data_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .bupd_i        (bupd_i),
    .bupd_pc_i     (bupd_pc_i),
    .bupd_taken_i  (bupd_taken_i),
    .halt_i        (halt_i),
    .pc_o          (pc_o),
    .bpr_o         (bpr_o),
    .flush_o       (flush_o),
    .latchn_o      (latchn_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ctl(input logic [11:0] pc_e, input logic fl_e, input logic la_e, input string tag);
    chk({tag, "_pc"}, 32'(pc_o), 32'(pc_e));
    chk({tag, "_addr"}, 32'(imem_addr_o), 32'(pc_e));
    chk({tag, "_flush"}, 32'(flush_o), 32'(fl_e));
    chk({tag, "_latchn"}, 32'(latchn_o), 32'(la_e));
  endtask

  initial begin
    RSTn = 1'b0; imem_data_i = NOP;
    stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; halt_i = 1'b0;
    bupd_i = 1'b0; bupd_pc_i = '0; bupd_taken_i = 1'b0;

    // reset held while stall and redirect requested
    tick();
    stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 12'h500;
    #1 ctl(12'h000, 1'b0, 1'b0, "rst_hold");
    tick();
    chk("rst_pc", 32'(pc_o), 32'h000);

    RSTn = 1'b1; stall_i = 1'b0; redirect_i = 1'b0;
    #1 ctl(12'h000, 1'b0, 1'b0, "post_rst");
    chk("post_rst_bpr", 32'(bpr_o), 32'h0);
    tick();
    ctl(12'h004, 1'b0, 1'b0, "seq4");
    tick();
    ctl(12'h008, 1'b0, 1'b0, "seq8");

    // wrap at top of address space
    redirect_i = 1'b1; redirect_pc_i = 12'hFFC;
    #1 chk("redir_ffc_flush", 32'(flush_o), 32'h1);
    tick();
    redirect_i = 1'b0;
    chk("at_ffc", 32'(pc_o), 32'hFFC);
    tick();
    chk("wrap", 32'(pc_o), 32'h000);

    // JAL prediction
    redirect_i = 1'b1; redirect_pc_i = 12'h010;
    tick();
    redirect_i = 1'b0; imem_data_i = JAL32;
    #1 chk("jal_bpr", 32'(bpr_o), 32'h1);
    tick();
    imem_data_i = NOP;
    chk("jal_target", 32'(pc_o), 32'h030);

    // 3-cycle stall at 0x020
    redirect_i = 1'b1; redirect_pc_i = 12'h020;
    tick();
    redirect_i = 1'b0; stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 ctl(12'h020, 1'b0, 1'b1, "stall");
      tick();
    end
    stall_i = 1'b0;
    #1 chk("stall_release_latchn", 32'(latchn_o), 32'h0);
    tick();
    chk("stall_advance", 32'(pc_o), 32'h024);

    // BHT training toward taken
    redirect_i = 1'b1; redirect_pc_i = 12'h040;
    tick();
    redirect_i = 1'b0; imem_data_i = BM8;
    #1 chk("b_fresh_bpr", 32'(bpr_o), 32'h0);
    stall_i = 1'b1; bupd_i = 1'b1; bupd_pc_i = 12'h040; bupd_taken_i = 1'b1;
    #1 chk("b_collide_old", 32'(bpr_o), 32'h0);
    tick();
    chk("b_upd1_bpr", 32'(bpr_o), 32'h1);
    chk("b_upd1_pc", 32'(pc_o), 32'h040);
    tick();
    bupd_i = 1'b0; stall_i = 1'b0;
    #1 chk("b_taken_bpr", 32'(bpr_o), 32'h1);
    tick();
    chk("b_taken_target", 32'(pc_o), 32'h038);

    // BHT training back to not-taken, with saturation at zero
    imem_data_i = NOP; redirect_i = 1'b1; redirect_pc_i = 12'h040;
    tick();
    redirect_i = 1'b0; imem_data_i = BM8;
    stall_i = 1'b1; bupd_i = 1'b1; bupd_taken_i = 1'b0;
    #1 chk("nt_ctr3", 32'(bpr_o), 32'h1);
    tick();
    chk("nt_ctr2", 32'(bpr_o), 32'h1);
    tick();
    chk("nt_ctr1", 32'(bpr_o), 32'h0);
    tick();
    tick();
    bupd_taken_i = 1'b1;
    #1 chk("nt_sat0", 32'(bpr_o), 32'h0);
    tick();
    bupd_i = 1'b0; stall_i = 1'b0;
    #1 chk("nt_ctr1_again", 32'(bpr_o), 32'h0);
    tick();
    chk("nt_fallthrough", 32'(pc_o), 32'h044);

    // redirect beats stall
    imem_data_i = NOP; redirect_i = 1'b1; redirect_pc_i = 12'h100; stall_i = 1'b1;
    #1 ctl(12'h044, 1'b1, 1'b0, "redir_stall");
    tick();
    redirect_i = 1'b0; stall_i = 1'b0;
    chk("redir_stall_pc", 32'(pc_o), 32'h100);

    // halt beats redirect, then everything ignored
    halt_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 12'h200;
    #1 ctl(12'h100, 1'b1, 1'b0, "halt_cyc");
    tick();
    halt_i = 1'b0; redirect_pc_i = 12'h300; stall_i = 1'b1;
    bupd_i = 1'b1; bupd_pc_i = 12'h040; bupd_taken_i = 1'b1;
    #1 ctl(12'h100, 1'b1, 1'b0, "halted1");
    tick();
    ctl(12'h100, 1'b1, 1'b0, "halted2");
    tick();
    ctl(12'h100, 1'b1, 1'b0, "halted3");

    // reset exits HALTED
    RSTn = 1'b0;
    #1 ctl(12'h100, 1'b0, 1'b0, "halt_rst_cyc");
    tick();
    chk("halt_rst_pc", 32'(pc_o), 32'h000);
    RSTn = 1'b1; redirect_i = 1'b0; stall_i = 1'b0; bupd_i = 1'b0;
    #1 ctl(12'h000, 1'b0, 1'b0, "run_again");
    tick();
    ctl(12'h004, 1'b0, 1'b0, "run_again4");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
